distance_smoother: RTL and testbench

DISTANCE_SMOOTHER -- requirements
Module: distance_smoother

---
 rtl/distance_pkg.sv | 14 +
 rtl/bin2bcd6.sv | 25 ++
 rtl/distance_smoother.sv | 138 +++++++++++++
 tb/tb_distance_smoother.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/distance_pkg.sv
// Shared constants and state encoding for the ultrasonic distance smoother.
package distance_pkg;

  localparam int unsigned DistW          = 6;
  localparam int unsigned NearCmDefault  = 10;
  localparam int unsigned FarCmDefault   = 14;
  localparam int unsigned TimeoutDefault = 100000000;

  typedef enum logic [0:0] {
    StFill,
    StRun
  } state_e;

endpackage

// File: rtl/bin2bcd6.sv
// Combinational 6-bit binary to two-digit BCD converter (0..63).
module bin2bcd6
  import distance_pkg::*;
(
  input  logic [DistW-1:0] bin,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  logic [DistW-1:0] rem;

  // Largest multiple of ten not above bin picks the tens digit.
  always_comb begin
    tens = '0;
    rem  = bin;
    for (int t = 6; t >= 1; t--) begin
      if (tens == '0 && bin >= DistW'(t * 10)) begin
        tens = 4'(t);
        rem  = bin - DistW'(t * 10);
      end
    end
    ones = 4'(rem);
  end

endmodule

// File: rtl/distance_smoother.sv
// Sliding-window mean of ultrasonic distance samples with BCD output,
// hysteretic proximity alarm and a stale-input watchdog.
module distance_smoother
  import distance_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NEAR_CM = NearCmDefault,
  parameter int unsigned FAR_CM  = FarCmDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic             CLK50MHZ,
  input  logic             reset,
  input  logic [DistW-1:0] dist_in,
  input  logic             dist_valid,
  input  logic             clear,
  output logic [DistW-1:0] dist_avg,
  output logic             avg_valid,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             near,
  output logic             stale
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned SumW = DistW + PtrW;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [DistW-1:0] NearTh   = DistW'(NEAR_CM);
  localparam logic [DistW-1:0] FarTh    = DistW'(FAR_CM);
  localparam logic [CntW-1:0]  TimeoutC = CntW'(TIMEOUT);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two between 2 and 16");
  end
  if (FAR_CM <= NEAR_CM) begin : g_bad_hyst
    $error("FAR_CM must exceed NEAR_CM");
  end

  state_e           state_q, state_d;
  logic [DistW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q;
  logic [SumW-1:0]  sum_q, sum_d;
  logic             upd_q, upd_d;
  logic             accept;
  logic [DistW-1:0] avg_d;
  logic [3:0]       tens_d, ones_d;
  logic [DistW-1:0] dist_avg_q;
  logic [3:0]       tens_q, ones_q;
  logic             avg_valid_q, near_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // clear wins over a coincident sample
  assign accept = dist_valid && !clear;
  assign sum_d  = sum_q + SumW'(dist_in) - SumW'(mem_q[ptr_q]);
  assign avg_d  = sum_q[SumW-1:PtrW];

  bin2bcd6 u_bcd (
    .bin  (avg_d),
    .tens (tens_d),
    .ones (ones_d)
  );

  always_ff @(posedge CLK50MHZ) begin
    if (reset) state_q <= StFill;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StFill;
    end else if (dist_valid && state_q == StFill && ptr_q == PtrW'(DEPTH - 1)) begin
      state_d = StRun;
    end
  end

  // The filling sample already lands in RUN, so it produces the first pulse.
  always_comb begin
    upd_d = accept && (state_d == StRun);
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      mem_q[ptr_q] <= dist_in;
      ptr_q        <= ptr_q + 1'b1;
      sum_q        <= sum_d;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      upd_q       <= 1'b0;
      avg_valid_q <= 1'b0;
      dist_avg_q  <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
    end else begin
      upd_q       <= upd_d;
      avg_valid_q <= upd_q && !clear;
      if (upd_q && !clear) begin
        dist_avg_q <= avg_d;
        tens_q     <= tens_d;
        ones_q     <= ones_d;
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset || clear) begin
      near_q <= 1'b0;
    end else if (avg_valid_q) begin
      if (dist_avg_q < NearTh)     near_q <= 1'b1;
      else if (dist_avg_q > FarTh) near_q <= 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dist_valid)             cnt_d = '0;
    else if (cnt_q != TimeoutC) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign dist_avg  = dist_avg_q;
  assign avg_valid = avg_valid_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign near      = near_q;
  assign stale     = (cnt_q == TimeoutC);

endmodule

// File: tb/tb_distance_smoother.sv
// Directed self-checking bench for distance_smoother (DEPTH=8, TIMEOUT=100).
module tb_distance_smoother;

  logic       CLK50MHZ = 1'b0;
  logic       reset, dist_valid, clear;
  logic [5:0] dist_in;
  logic [5:0] dist_avg;
  logic       avg_valid;
  logic [3:0] bcd_tens, bcd_ones;
  logic       near, stale;

  int n_checks = 0;
  int n_errors = 0;

  logic       av;
  logic [5:0] avg;
  logic [3:0] tn, on;

  distance_smoother #(
    .DEPTH   (8),
    .NEAR_CM (10),
    .FAR_CM  (14),
    .TIMEOUT (100)
  ) dut (
    .CLK50MHZ   (CLK50MHZ),
    .reset      (reset),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .clear      (clear),
    .dist_avg   (dist_avg),
    .avg_valid  (avg_valid),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .near       (near),
    .stale      (stale)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe, then sample the outputs one cycle after the accepting edge.
  task automatic send(input logic [5:0] d);
    @(negedge CLK50MHZ);
    dist_valid = 1'b1;
    dist_in    = d;
    @(negedge CLK50MHZ);
    dist_valid = 1'b0;
    @(negedge CLK50MHZ);
    av  = avg_valid;
    avg = dist_avg;
    tn  = bcd_tens;
    on  = bcd_ones;
  endtask

  task automatic window_near(input logic [5:0] v, input logic exp_near, input string tag);
    repeat (8) send(v);
    check({tag, "_avg"}, avg, v);
    @(negedge CLK50MHZ);
    check({tag, "_near"}, near, exp_near);
  endtask

  initial begin
    reset = 1'b1; dist_valid = 1'b0; clear = 1'b0; dist_in = '0;
    repeat (3) @(negedge CLK50MHZ);
    check("rst_avg", dist_avg, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_bcd", {bcd_tens, bcd_ones}, 0);
    check("rst_near", near, 0);
    check("rst_stale", stale, 0);
    reset = 1'b0;

    // Fill: no pulse until the 8th sample
    for (int i = 1; i <= 7; i++) begin
      send(6'd20);
      check("fill_noav", av, 0);
    end
    send(6'd20);
    check("fill_av", av, 1);
    check("fill_avg", avg, 20);
    check("fill_bcd", {tn, on}, 8'h20);

    send(6'd60);
    check("slide_avg", avg, 25);
    check("slide_bcd", {tn, on}, 8'h25);

    repeat (8) send(6'd63);
    check("max_avg", avg, 63);
    check("max_bcd", {tn, on}, 8'h63);

    window_near(6'd12, 1'b0, "hyst12a");
    window_near(6'd9,  1'b1, "hyst9");
    check("bcd9", {tn, on}, 8'h09);
    window_near(6'd12, 1'b1, "hyst12b");
    window_near(6'd14, 1'b1, "hyst14");
    window_near(6'd15, 1'b0, "hyst15");

    // Stale watchdog
    @(negedge CLK50MHZ); dist_valid = 1'b1; dist_in = 6'd15;
    @(negedge CLK50MHZ); dist_valid = 1'b0;
    repeat (99) @(negedge CLK50MHZ);
    check("stale_early", stale, 0);
    @(negedge CLK50MHZ);
    check("stale_rise", stale, 1);
    repeat (20) @(negedge CLK50MHZ);
    check("stale_sat", stale, 1);
    @(negedge CLK50MHZ); dist_valid = 1'b1;
    check("stale_pre", stale, 1);
    @(negedge CLK50MHZ); dist_valid = 1'b0;
    check("stale_clr", stale, 0);

    // Clear coinciding with a sample
    repeat (8) send(6'd5);
    @(negedge CLK50MHZ);
    check("pre_clr_near", near, 1);
    clear = 1'b1; dist_valid = 1'b1; dist_in = 6'd5;
    @(negedge CLK50MHZ);
    clear = 1'b0; dist_valid = 1'b0;
    check("clr_near", near, 0);
    check("clr_hold", dist_avg, 5);
    @(negedge CLK50MHZ);
    check("clr_noav", avg_valid, 0);
    for (int i = 1; i <= 7; i++) begin
      send(6'd30);
      check("clr_fill_noav", av, 0);
    end
    send(6'd30);
    check("clr_fill_av", av, 1);
    check("clr_fill_avg", avg, 30);

    // Reset mid-window discards samples
    repeat (3) send(6'd40);
    @(negedge CLK50MHZ); reset = 1'b1;
    @(negedge CLK50MHZ); reset = 1'b0;
    check("rst2_avg", dist_avg, 0);
    check("rst2_bcd", {bcd_tens, bcd_ones}, 0);
    check("rst2_near", near, 0);

    // Back-to-back strobes 4,8,...,40
    @(negedge CLK50MHZ); dist_valid = 1'b1; dist_in = 6'd4;
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK50MHZ);
      check("b2b_valid", avg_valid, (j >= 9 && j <= 11) ? 1 : 0);
      if (j == 9)  check("b2b_avg8", dist_avg, 18);
      if (j == 10) check("b2b_avg9", dist_avg, 22);
      if (j == 11) check("b2b_avg10", dist_avg, 26);
      if (j < 10) dist_in = 6'((j + 1) * 4);
      else        dist_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
